// File: rtl/status_led_ctrl.sv
// Board status-LED driver: synchronises async status bits into clk_125 and drives
// each LED as off / direct / stretched activity / blink, with a lamp-test override.
module status_led_ctrl #(
  parameter int unsigned NUM_LEDS          = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned STRETCH_CYCLES    = 6250000,
  parameter int unsigned BLINK_HALF_CYCLES = 31250000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic                  clk_125,
  input  logic                  global_reset_n,
  input  logic [NUM_LEDS-1:0]   status_in,
  input  logic [2*NUM_LEDS-1:0] mode,
  input  logic                  lamp_test,
  output logic [NUM_LEDS-1:0]   led_out
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_DIRECT  = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  localparam int unsigned CW = $clog2(STRETCH_CYCLES + 1);
  // A single-cycle half-period still needs a 1-bit prescaler to keep widths legal.
  localparam int unsigned PW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_MAX   = PW'(BLINK_HALF_CYCLES - 1);

  logic [NUM_LEDS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_LEDS-1:0] sDelay_q;
  logic [CW-1:0]       stretchCnt_q [NUM_LEDS];
  logic [CW-1:0]       stretchCnt_d [NUM_LEDS];
  logic [PW-1:0]       pcnt_q;
  logic [PW-1:0]       pcnt_d;
  logic                phase_q;
  logic                phase_d;
  logic [NUM_LEDS-1:0] ledOut_q;
  logic [NUM_LEDS-1:0] ledOut_d;

  logic [NUM_LEDS-1:0] syncStatus;
  logic [NUM_LEDS-1:0] rise;
  logic [NUM_LEDS-1:0] on;
  logic                pcntWrap;
  mode_e               chMode;

  assign syncStatus = sync_q[SYNC_STAGES-1];
  assign rise       = syncStatus & ~sDelay_q;

  always_comb begin
    pcntWrap = (pcnt_q == PCNT_MAX);
    pcnt_d   = pcntWrap ? '0 : pcnt_q + PW'(1);
    phase_d  = phase_q ^ pcntWrap;
  end

  // Counters of channels not in STRETCH are held at zero, so re-entering
  // STRETCH never resumes an old pulse.
  always_comb begin
    chMode = MODE_OFF;
    on     = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      stretchCnt_d[i] = '0;
      chMode          = mode_e'(mode[2*i +: 2]);
      case (chMode)
        MODE_OFF: on[i] = 1'b0;
        MODE_DIRECT: on[i] = syncStatus[i];
        MODE_STRETCH: begin
          on[i] = rise[i] | (stretchCnt_q[i] != '0);
          if (rise[i]) begin
            stretchCnt_d[i] = CNT_RELOAD;
          end else if (stretchCnt_q[i] != '0) begin
            stretchCnt_d[i] = stretchCnt_q[i] - CW'(1);
          end
        end
        MODE_BLINK: on[i] = syncStatus[i] & phase_q;
        default: on[i] = 1'b0;
      endcase
    end
    ledOut_d = (on | {NUM_LEDS{lamp_test}}) ^ {NUM_LEDS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk_125 or negedge global_reset_n) begin
    if (!global_reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sDelay_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        stretchCnt_q[i] <= '0;
      end
      pcnt_q   <= '0;
      phase_q  <= 1'b0;
      ledOut_q <= {NUM_LEDS{ACTIVE_LOW}};
    end else begin
      sync_q[0] <= status_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      sDelay_q <= syncStatus;
      for (int i = 0; i < NUM_LEDS; i++) begin
        stretchCnt_q[i] <= stretchCnt_d[i];
      end
      pcnt_q   <= pcnt_d;
      phase_q  <= phase_d;
      ledOut_q <= ledOut_d;
    end
  end

  assign led_out = ledOut_q;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl: a steady-state vector table plus hand-written
// sequences for latency, stretch retrigger, blink phase, lamp test and async reset.
module tb_status_led_ctrl;

  logic       clk;
  logic       rstN;
  logic [3:0] statusIn;
  logic [7:0] modeIn;
  logic       lampTest;
  logic [3:0] ledOut;

  int checks;
  int failures;
  int litCount;
  int litRuns;
  int firstLit;
  int badCount;
  bit prevLit;

  typedef struct packed {
    logic [3:0] status;
    logic [7:0] mode;
    logic       lamp;
    logic [3:0] expLed;
  } vec_t;

  vec_t vecs [11];

  status_led_ctrl #(
    .NUM_LEDS(4),
    .SYNC_STAGES(2),
    .STRETCH_CYCLES(4),
    .BLINK_HALF_CYCLES(8),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_125(clk),
    .global_reset_n(rstN),
    .status_in(statusIn),
    .mode(modeIn),
    .lamp_test(lampTest),
    .led_out(ledOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [7:0] md, input logic lamp);
    statusIn = st;
    modeIn   = md;
    lampTest = lamp;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b", name, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic sampleLit();
    step();
    if (ledOut[1] == 1'b0) begin
      litCount++;
      if (!prevLit) litRuns++;
      prevLit = 1'b1;
    end else begin
      prevLit = 1'b0;
    end
  endtask

  task automatic resetCounts();
    litCount = 0;
    litRuns  = 0;
    prevLit  = 1'b0;
  endtask

  // Two rises on ch1 separated by gapSteps cycles; status is held high after the second.
  task automatic runRetrigger(input int gapSteps, input int expLit, input string name);
    applyStimulus(4'b0000, 8'h08, 1'b0);
    repeat (8) step();
    resetCounts();
    applyStimulus(4'b0010, 8'h08, 1'b0);
    sampleLit();
    applyStimulus(4'b0000, 8'h08, 1'b0);
    for (int k = 1; k < gapSteps; k++) sampleLit();
    applyStimulus(4'b0010, 8'h08, 1'b0);
    for (int k = 0; k < 14; k++) sampleLit();
    checkValue({name, "Len"}, litCount, expLit);
    checkValue({name, "Runs"}, litRuns, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstN     = 1'b0;
    applyStimulus(4'hF, 8'hFF, 1'b0);

    vecs[0]  = '{status: 4'b1010, mode: 8'h55, lamp: 1'b0, expLed: 4'b0101};
    vecs[1]  = '{status: 4'b0101, mode: 8'h55, lamp: 1'b0, expLed: 4'b1010};
    vecs[2]  = '{status: 4'b1111, mode: 8'h55, lamp: 1'b0, expLed: 4'b0000};
    vecs[3]  = '{status: 4'b1111, mode: 8'hAA, lamp: 1'b0, expLed: 4'b1111};
    vecs[4]  = '{status: 4'b1111, mode: 8'h00, lamp: 1'b0, expLed: 4'b1111};
    vecs[5]  = '{status: 4'b1111, mode: 8'h00, lamp: 1'b1, expLed: 4'b0000};
    vecs[6]  = '{status: 4'b0011, mode: 8'h05, lamp: 1'b0, expLed: 4'b1100};
    vecs[7]  = '{status: 4'b0011, mode: 8'h50, lamp: 1'b0, expLed: 4'b1111};
    vecs[8]  = '{status: 4'b1100, mode: 8'h50, lamp: 1'b0, expLed: 4'b0011};
    vecs[9]  = '{status: 4'b0000, mode: 8'h55, lamp: 1'b1, expLed: 4'b0000};
    vecs[10] = '{status: 4'b0000, mode: 8'h55, lamp: 1'b0, expLed: 4'b1111};

    // Reset held with everything asking to light, then released with all modes OFF.
    repeat (3) step();
    checkOutput("resetHeld", ledOut, 4'b1111);
    applyStimulus(4'hF, 8'h00, 1'b0);
    rstN = 1'b1;
    repeat (3) step();
    checkOutput("resetRelease", ledOut, 4'b1111);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].status, vecs[i].mode, vecs[i].lamp);
      repeat (4) step();
      checkOutput($sformatf("vec%0d", i), ledOut, vecs[i].expLed);
    end

    // DIRECT latency on ch0: three cycles for each edge.
    applyStimulus(4'b0000, 8'h01, 1'b0);
    repeat (4) step();
    applyStimulus(4'b0001, 8'h01, 1'b0);
    repeat (2) step();
    checkOutput("directRiseEarly", ledOut, 4'b1111);
    step();
    checkOutput("directRise", ledOut, 4'b1110);
    applyStimulus(4'b0000, 8'h01, 1'b0);
    repeat (2) step();
    checkOutput("directFallEarly", ledOut, 4'b1110);
    step();
    checkOutput("directFall", ledOut, 4'b1111);

    // Single STRETCH rise on ch1, held high.
    applyStimulus(4'b0000, 8'h08, 1'b0);
    repeat (6) step();
    applyStimulus(4'b0010, 8'h08, 1'b0);
    litCount = 0;
    firstLit = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ledOut[1] == 1'b0) begin
        litCount++;
        if (firstLit < 0) firstLit = k;
      end
    end
    checkValue("stretchSingleLen", litCount, 4);
    checkValue("stretchSingleLatency", firstLit, 3);

    runRetrigger(2, 6, "stretchRetrig");
    runRetrigger(4, 8, "stretchReloadAtZero");

    // BLINK ch2 with status high from reset.
    rstN = 1'b0;
    applyStimulus(4'b0100, 8'h30, 1'b0);
    step();
    rstN = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      checkOutput($sformatf("blinkEdge%0d", k), ledOut,
                  ((((k - 1) / 8) % 2) == 1) ? 4'b1011 : 4'b1111);
    end
    applyStimulus(4'b0000, 8'h30, 1'b0);
    repeat (2) step();
    checkOutput("blinkStopEarly", ledOut, 4'b1011);
    step();
    checkOutput("blinkStop", ledOut, 4'b1111);
    badCount = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ledOut !== 4'b1111) badCount++;
    end
    checkValue("blinkStopSteady", badCount, 0);

    // Lamp test over all-OFF modes.
    applyStimulus(4'b0000, 8'h00, 1'b1);
    step();
    checkOutput("lampOn", ledOut, 4'b0000);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    step();
    checkOutput("lampOff", ledOut, 4'b1111);

    // ch1 STRETCH -> DIRECT mid-pulse while synced status is low.
    applyStimulus(4'b0000, 8'h08, 1'b0);
    repeat (8) step();
    applyStimulus(4'b0010, 8'h08, 1'b0);
    step();
    applyStimulus(4'b0000, 8'h08, 1'b0);
    repeat (2) step();
    checkOutput("switchPreLit", ledOut, 4'b1101);
    applyStimulus(4'b0000, 8'h04, 1'b0);
    step();
    checkOutput("switchToDirect", ledOut, 4'b1111);

    // Async reset two cycles into a STRETCH pulse.
    applyStimulus(4'b0000, 8'h08, 1'b0);
    repeat (8) step();
    applyStimulus(4'b0010, 8'h08, 1'b0);
    repeat (3) step();
    checkOutput("preResetLit1", ledOut, 4'b1101);
    step();
    checkOutput("preResetLit2", ledOut, 4'b1101);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncReset", ledOut, 4'b1111);
    applyStimulus(4'b0000, 8'h08, 1'b0);
    repeat (3) step();
    rstN = 1'b1;
    badCount = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ledOut !== 4'b1111) badCount++;
    end
    checkValue("postResetDark", badCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
